// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types and sizing helpers for the TDM receive demultiplexer.
//   state_t  : receiver FSM states (HUNT for frame sync, RUN once aligned)
//   NCH_DEF  : default channel count
//   W_DEF    : default channel word width
//   cnt_w()  : counter width for a counter holding 0..n-1 (never below 1)
package tdm_pkg;

  typedef enum logic {HUNT, RUN} state_t;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: bit-in-slot and slot-in-frame position counters.
//   clk, rst       : clock, async active-high reset
//   adv            : one serial bit accepted in normal flow
//   restart        : sync restart, current bit becomes bit 0 of slot 0
//   slot           : current slot index
//   last_bit       : current bit is the last bit of its slot
//   frame_boundary : next bit starts a new frame (slot 0, bit 0)
module tdm_slot_ctr import tdm_pkg::*; #(
  parameter int NCH       = NCH_DEF,
  parameter int SLOT_BITS = W_DEF,
  parameter int SW        = cnt_w(NCH),
  parameter int BW        = cnt_w(W_DEF + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          restart,
  output logic [SW-1:0] slot,
  output logic          last_bit,
  output logic          frame_boundary
);

  logic [BW-1:0] bit_cnt;

  assign last_bit       = (bit_cnt == BW'(SLOT_BITS - 1));
  assign frame_boundary = (slot == '0) && (bit_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      slot    <= '0;
    end else if (restart) begin
      // the sync bit itself is bit 0, so the next expected bit is 1
      bit_cnt <= BW'(1);
      slot    <= '0;
    end else if (adv) begin
      if (last_bit) begin
        bit_cnt <= '0;
        slot    <= (slot == SW'(NCH - 1)) ? '0 : slot + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM stream -> NCH parallel channel words.
//   clk, rst   : clock, async active-high reset
//   din        : serial bit, MSB first, sampled when en=1
//   en         : bit strobe
//   sync       : frame marker (qualified by en), din is bit 0 of slot 0
//   dout       : channel words, slot k at [k*W +: W]
//   dout_valid : one-cycle per-slot pulse when that word updates
//   frame_err  : one-cycle pulse on a misaligned sync
//   parity_err : one-cycle per-slot even-parity failure
// Build option: TDM_PARITY_EN adds one even-parity bit after each word.
module tdm_demux import tdm_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [NCH*W-1:0] dout,
  output logic [NCH-1:0]   dout_valid,
  output logic             frame_err,
  output logic [NCH-1:0]   parity_err
);

`ifdef TDM_PARITY_EN
  localparam int SB = W + 1;
  localparam int SR = W;      // data bits held while the parity bit arrives
`else
  localparam int SB = W;
  localparam int SR = W - 1;  // last data bit is taken straight from din
`endif
  localparam int SW = cnt_w(NCH);
  localparam int BW = cnt_w(W + 1);

  state_t                 state, state_nxt;
  logic [SR-1:0]          shreg;
  logic [W-1:0]           word;
  logic [SW-1:0]          slot;
  logic                   last_bit, frame_boundary;
  logic                   adv, restart, misalign, complete;
  logic [NCH-1:0]         hit;
  logic [NCH-1:0][W-1:0]  dout_q;

  tdm_slot_ctr #(.NCH(NCH), .SLOT_BITS(SB), .SW(SW), .BW(BW)) u_ctr (
    .clk            (clk),
    .rst            (rst),
    .adv            (adv),
    .restart        (restart),
    .slot           (slot),
    .last_bit       (last_bit),
    .frame_boundary (frame_boundary)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    restart   = 1'b0;
    misalign  = 1'b0;
    case (state)
      HUNT: if (en && sync) begin
        state_nxt = RUN;
        restart   = 1'b1;
      end
      RUN: if (en) begin
        // sync anywhere but a frame boundary (including a slot's last bit)
        // drops the partial word and realigns on this bit
        if (sync && !frame_boundary) begin
          misalign = 1'b1;
          restart  = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign complete = adv && last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          shreg <= '0;
    else if (restart) shreg <= SR'(din);
    else if (adv)     shreg <= SR'({shreg, din});
  end

`ifdef TDM_PARITY_EN
  logic perr_bit;
  assign word     = shreg;
  assign perr_bit = ^{shreg, din};
`else
  assign word = {shreg, din};
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign hit[k] = complete && (slot == SW'(k));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      dout_valid <= '0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= hit;
      frame_err  <= misalign;
      for (int k = 0; k < NCH; k++)
        if (hit[k]) dout_q[k] <= word;
    end
  end

`ifdef TDM_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= '0;
    else     parity_err <= hit & {NCH{perr_bit}};
  end
`else
  assign parity_err = '0;
`endif

  assign dout = dout_q;

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Receive-side time-division demultiplexer: the inverse of the 2:1 and N:1 select muxes used to merge channels onto one wire. It takes a single-bit serial stream carrying NCH interleaved W-bit channel words, delimited by a frame-sync marker, and recovers the words. Each word is presented on its own parallel output with a one-cycle valid pulse. It sits at the far end of a serialized link, ahead of per-channel consumers.

## Interface
- NCH, 4: number of channels (slots) per frame, ≥2
- W, 8: bits per channel word, ≥2
- clk  input  1  single clock; all logic rising-edge
- rst  input  1  reset, asynchronous, active-high
- din  input  1  serial data bit, sampled only when en=1
- en  input  1  bit strobe; one serial bit per cycle with en=1
- sync  input  1  frame marker; qualified by en; marks din as bit 0 of slot 0
- dout  output  NCH*W  channel words; slot k occupies [k*W +: W]
- dout_valid  output  NCH  one-cycle pulse per slot when its word updates
- frame_err  output  1  one-cycle pulse on misaligned sync
- parity_err  output  NCH  one-cycle per-slot parity failure (see Configuration)

## Operation
- Reset values:
  - dout=0, dout_valid=0, frame_err=0, parity_err=0.
  - State HUNT; slot and bit counters 0; shift register 0.
- HUNT:
  - en=1 without sync is ignored.
  - en=1 with sync: shift din in as bit 0 of slot 0, set bit_cnt=1, go to RUN.
- RUN, on each en=1:
  - Shift din into the shift register. Bits arrive MSB first.
  - Advance bit_cnt.
  - Cycles with en=0 hold all state.
- Slot completion:
  - Triggered when the last bit of a slot is sampled: bit_cnt=W-1, or bit W when the parity bit is enabled.
  - At that same edge, load dout[slot] with the completed word and pulse dout_valid[slot].
  - Then advance slot and clear bit_cnt. slot wraps NCH-1 → 0.
  - Other slots' dout hold their values.
- Sync handling in RUN:
  - sync at a frame boundary (slot=0, bit_cnt=0) is accepted silently.
  - sync elsewhere is misaligned:
    - Pulse frame_err.
    - Discard the partial word; it is not emitted.
    - Restart with din as bit 0 of slot 0 (bit_cnt=1, slot=0).
    - Stay in RUN.
- Sync on the last bit of a slot is also misaligned: no completion, frame_err pulses, resync as above.
- Absence of sync at a frame boundary is not an error: the block freewheels on its counters.
- Reset asserted mid-word: all state clears asynchronously. Return to HUNT; no valid pulse.

## Timing
- Latency: the last bit is sampled at edge T; dout and dout_valid are visible after edge T and dout_valid drops after T+1 unless another completion occurs.
- Back-to-back en sustains full rate of 1 bit/cycle. A word completes every W cycles, or W+1 with the parity bit enabled.
- frame_err and parity_err are registered and aligned to the same edge as the event.
- Only one slot can complete per cycle, so dout_valid is one-hot or zero.

## Configuration
- TDM_PARITY_EN defined:
  - Each slot carries W+1 bits: W data bits, then 1 even-parity bit.
  - At completion, if the XOR of data and parity bits is 1, pulse parity_err[slot] together with dout_valid[slot].
  - The data is still delivered.
- TDM_PARITY_EN undefined:
  - Slots are W bits.
  - parity_err is tied to 0.

## Structure
- Package tdm_pkg:
  - State enum {HUNT, RUN}.
  - Default NCH/W constants.
  - Counter width derivation: clog2 of NCH, and of W+1.
- Sub-module tdm_slot_ctr: holds bit_cnt and slot with enable, wrap, and sync-restart inputs. It outputs the last_bit and frame_boundary flags.
- The top level holds the FSM, shift register, output registers and error logic.

## Test plan
- Reset, then a sync frame with NCH=4, W=8, words A5,3C,FF,00, then en continuous → dout_valid pulses 0001,0010,0100,1000 at 8-cycle spacing; dout = 00_FF_3C_A5.
- en toggling 1/0 every cycle during the same frame → identical words; valid pulses 16 cycles apart; state held on en=0.
- en=1 without sync for 40 cycles after reset → no dout_valid, dout stays 0.
- sync at slot 1, bit 3 → frame_err pulses once; no slot-1 valid; next words land starting at slot 0.
- rst asserted at slot 2, bit 5 → outputs 0 immediately (asynchronous); following din ignored until the next sync.
- TDM_PARITY_EN: send 0x81 with parity bit 1 → parity_err[k] pulses with dout_valid[k]; with parity bit 0 → no parity_err.
